// File: rtl/count_mon_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | count_mon_pkg : shared FSM encoding and saturation helpers            |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
package count_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ALARM = 2'd2
    } state_t;

    localparam logic signed [7:0] c_sat_max = 8'sh7f;
    localparam logic signed [7:0] c_sat_min = 8'sh80;

    // One wrap step; holds at the limits instead of rolling over.
    function automatic logic signed [7:0] sat_step(
        input logic signed [7:0] cur,
        input logic              inc,
        input logic              dec
    );
        if (inc && (cur != c_sat_max)) begin
            return cur + 8'sd1;
        end else if (dec && (cur != c_sat_min)) begin
            return cur - 8'sd1;
        end
        return cur;
    endfunction

endpackage
`default_nettype wire

// File: rtl/count_wrap_monitor_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | count_wrap_monitor_if : counter sample in, wrap status out            |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
interface count_wrap_monitor_if;
    import count_mon_pkg::*;

    logic [3:0]        q_in;
    logic              m_in;
    logic              clear;
    logic              ovf_pulse;
    logic              unf_pulse;
    logic signed [7:0] net_wraps;
    logic              alarm;

    modport master (
        output q_in, m_in, clear,
        input  ovf_pulse, unf_pulse, net_wraps, alarm
    );

    modport slave (
        input  q_in, m_in, clear,
        output ovf_pulse, unf_pulse, net_wraps, alarm
    );

endinterface
`default_nettype wire

// File: rtl/count_wrap_monitor_wrap_detect.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | wrap_detect : previous-sample register and raw 15->0 / 0->15 flags    |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module wrap_detect
    import count_mon_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       i_clear,
    input  wire logic [3:0] i_q,
    input  wire logic       i_m,
    output logic            o_ovf_raw,
    output logic            o_unf_raw
);

    logic [3:0] r_q_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q_prev <= 4'd0;
        end else if (i_clear) begin
            r_q_prev <= 4'd0;
        end else begin
            r_q_prev <= i_q;
        end
    end

    // Direction must agree with the wrap; a 15->0 seen while counting down is a jump.
    assign o_ovf_raw = (r_q_prev == 4'd15) && (i_q == 4'd0)  &&  i_m;
    assign o_unf_raw = (r_q_prev == 4'd0)  && (i_q == 4'd15) && !i_m;

endmodule
`default_nettype wire

// File: rtl/count_wrap_monitor.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | count_wrap_monitor : wrap pulses, saturating net count, sticky alarm  |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module count_wrap_monitor
    import count_mon_pkg::*;
#(
    parameter int THRESH = 4
) (
    input  wire logic           clk,
    input  wire logic           reset,
    count_wrap_monitor_if.slave bus
);

    localparam logic signed [7:0] c_thresh_pos = 8'(THRESH);
    localparam logic signed [7:0] c_thresh_neg = -c_thresh_pos;

    state_t            r_state;
    logic              r_ovf;
    logic              r_unf;
    logic              r_alarm;
    logic signed [7:0] r_net;

    logic              w_ovf_raw;
    logic              w_unf_raw;
    logic              w_ovf;
    logic              w_unf;
    logic signed [7:0] w_net_next;
    logic              w_hit;

    wrap_detect u_wrap_detect (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (bus.clear),
        .i_q       (bus.q_in),
        .i_m       (bus.m_in),
        .o_ovf_raw (w_ovf_raw),
        .o_unf_raw (w_unf_raw)
    );

    // q_prev is meaningless until one sample has been taken after reset/clear.
    assign w_ovf      = w_ovf_raw && (r_state != ST_IDLE);
    assign w_unf      = w_unf_raw && (r_state != ST_IDLE);
    assign w_net_next = sat_step(r_net, w_ovf, w_unf);
    assign w_hit      = (w_ovf || w_unf) &&
                        ((w_net_next == c_thresh_pos) || (w_net_next == c_thresh_neg));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_alarm <= 1'b0;
            r_net   <= 8'sd0;
        end else if (bus.clear) begin
            r_state <= ST_IDLE;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_alarm <= 1'b0;
            r_net   <= 8'sd0;
        end else begin
            r_ovf <= w_ovf;
            r_unf <= w_unf;
            r_net <= w_net_next;
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_TRACK;
                    r_alarm <= 1'b0;
                end
                ST_TRACK: begin
                    if (w_hit) begin
                        r_state <= ST_ALARM;
                        r_alarm <= 1'b1;
                    end
                end
                ST_ALARM: begin
                    r_alarm <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_alarm <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ovf_pulse = r_ovf;
    assign bus.unf_pulse = r_unf;
    assign bus.net_wraps = r_net;
    assign bus.alarm     = r_alarm;

endmodule
`default_nettype wire

// File: tb/tb_count_wrap_monitor.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_count_wrap_monitor : scoreboard bench for count_wrap_monitor       |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_count_wrap_monitor;

    localparam int THRESH = 4;

    logic clk;
    logic reset;

    count_wrap_monitor_if bus ();

    count_wrap_monitor #(.THRESH(THRESH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic ovf;
        logic unf;
        int   net;
        logic alarm;
    } exp_t;

    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit m_valid = 0;
    int m_prev  = 0;
    int m_net   = 0;
    bit m_alarm = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_prev  = 0;
        m_net   = 0;
        m_alarm = 0;
    endtask

    task automatic compare_outputs(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_ovf"},   int'(bus.ovf_pulse),         int'(e.ovf));
        check({tag, "_unf"},   int'(bus.unf_pulse),         int'(e.unf));
        check({tag, "_net"},   int'($signed(bus.net_wraps)), e.net);
        check({tag, "_alarm"}, int'(bus.alarm),             int'(e.alarm));
    endtask

    // Drive one sample, push the model's prediction, clock it, compare.
    task automatic step(input int q, input bit m, input bit clr, input string tag);
        exp_t e;
        bit ov, un;
        bus.q_in  = 4'(q);
        bus.m_in  = m;
        bus.clear = clr;
        e.ovf = 0;
        e.unf = 0;
        if (clr) begin
            model_reset();
        end else if (!m_valid) begin
            m_valid = 1;
            m_prev  = q;
        end else begin
            ov = (m_prev == 15) && (q == 0) && m;
            un = (m_prev == 0) && (q == 15) && !m;
            if (ov && m_net < 127)  m_net++;
            if (un && m_net > -128) m_net--;
            if ((ov || un) && (m_net == THRESH || m_net == -THRESH)) m_alarm = 1;
            e.ovf  = ov;
            e.unf  = un;
            m_prev = q;
        end
        e.net   = m_net;
        e.alarm = m_alarm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_outputs(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ovf"},   int'(bus.ovf_pulse),          0);
        check({tag, "_unf"},   int'(bus.unf_pulse),          0);
        check({tag, "_net"},   int'($signed(bus.net_wraps)), 0);
        check({tag, "_alarm"}, int'(bus.alarm),              0);
    endtask

    initial begin
        reset     = 1'b0;
        bus.q_in  = 4'd0;
        bus.m_in  = 1'b0;
        bus.clear = 1'b0;
        model_reset();
        #12;
        check_all_zero("reset");
        reset = 1'b1;

        // Single overflow
        step(13, 1, 0, "ovf_a");
        step(14, 1, 0, "ovf_b");
        step(15, 1, 0, "ovf_c");
        step(0,  1, 0, "ovf_d");
        check("ovf_pulse_seen", int'(bus.ovf_pulse), 1);
        check("ovf_net_one", int'($signed(bus.net_wraps)), 1);

        // Single underflow back to zero
        step(2,  0, 0, "unf_a");
        step(1,  0, 0, "unf_b");
        step(0,  0, 0, "unf_c");
        step(15, 0, 0, "unf_d");
        check("unf_pulse_seen", int'(bus.unf_pulse), 1);
        check("unf_net_zero", int'($signed(bus.net_wraps)), 0);

        // Four up-wraps raise the alarm together with the fourth pulse
        for (int i = 0; i < 4; i++) begin
            step(15, 1, 0, "up4_hi");
            step(0,  1, 0, "up4_wrap");
        end
        check("alarm_with_pulse", int'(bus.alarm & bus.ovf_pulse), 1);
        check("alarm_net_four", int'($signed(bus.net_wraps)), 4);
        step(15, 0, 0, "down_one");
        check("sticky_net_three", int'($signed(bus.net_wraps)), 3);
        check("sticky_alarm", int'(bus.alarm), 1);

        // Wrong-direction and non-adjacent jumps
        step(0,  0, 0, "wrongdir_dn");
        step(15, 1, 0, "wrongdir_up");
        step(5,  1, 0, "jump_a");
        step(9,  1, 0, "jump_b");
        check("nopulse_net", int'($signed(bus.net_wraps)), 3);

        // Reset mid-count; released with q_in=0 after 15
        step(15, 1, 0, "pre_reset");
        #2 reset = 1'b0;
        #2;
        check_all_zero("async_reset");
        model_reset();
        bus.q_in = 4'd0;
        #3 reset = 1'b1;
        step(0, 1, 0, "post_reset");
        check_all_zero("post_reset_zero");

        // Saturation at +127
        for (int i = 0; i < 130; i++) begin
            step(15, 1, 0, "sat_hi");
            step(0,  1, 0, "sat_wrap");
        end
        check("sat_net_127", int'($signed(bus.net_wraps)), 127);

        // Clear coincident with a wrap wins
        step(15, 1, 0, "clr_pre");
        step(0,  1, 1, "clr_wrap");
        check_all_zero("clr_zero");
        step(15, 1, 0, "clr_first");
        step(0,  1, 0, "clr_resume");
        check("resume_net_one", int'($signed(bus.net_wraps)), 1);

        // Underflow saturation toward -128 and negative alarm
        for (int i = 0; i < 131; i++) begin
            step(0,  0, 0, "neg_lo");
            step(15, 0, 0, "neg_wrap");
        end
        check("sat_net_m128", int'($signed(bus.net_wraps)), -128);

        // Random traffic biased toward wraps, with occasional clears
        for (int i = 0; i < 400; i++) begin
            int q;
            bit m, c;
            q = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                            : (($urandom_range(0, 1) == 0) ? 0 : 15);
            m = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 40) == 0);
            step(q, m, c, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/count_wrap_monitor.md
COUNT_WRAP_MONITOR -- requirements
Module: count_wrap_monitor

Interface
REQ-001 Parameter THRESH, default 4, meaning wrap-count magnitude that raises the alarm (legal range 1..127).
REQ-002 clk  input  1  single clock; all flops rise-edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 q_in  input  4  count value from the upstream 4-bit up/down counter.
REQ-005 m_in  input  1  direction of the upstream counter: 1 = up, 0 = down.
REQ-006 clear  input  1  synchronous clear of all monitor state, active-high.
REQ-007 ovf_pulse  output  1  one-cycle pulse on an up-direction wrap from 15 to 0.
REQ-008 unf_pulse  output  1  one-cycle pulse on a down-direction wrap from 0 to 15.
REQ-009 net_wraps  output  8  signed two's-complement net wrap count.
REQ-010 alarm  output  1  sticky alarm, high while the FSM is in ALARM.

Function
REQ-011 The block SHALL register q_in every cycle into q_prev and compare the current q_in against q_prev.
REQ-012 Overflow SHALL be detected when q_prev==4'd15, q_in==4'd0 and m_in==1; ovf_pulse SHALL be high for exactly the cycle after that edge.
REQ-013 Underflow SHALL be detected when q_prev==4'd0, q_in==4'd15 and m_in==0; unf_pulse SHALL be high for exactly the cycle after that edge.
REQ-014 Transitions 15->0 with m_in==0, 0->15 with m_in==1, or any non-adjacent jump SHALL NOT produce a pulse.
REQ-015 ovf_pulse and unf_pulse SHALL never be high in the same cycle.
REQ-016 net_wraps SHALL increment on overflow and decrement on underflow on the same edge that registers the pulse, saturating at +127 and -128 (no wrap).
REQ-017 The FSM SHALL have states IDLE, TRACK and ALARM.
REQ-018 IDLE means no valid q_prev; the first clocked sample SHALL move IDLE->TRACK with no detection on that edge.
REQ-019 TRACK->ALARM SHALL occur on the same edge at which the updated net_wraps reaches +THRESH or -THRESH, so alarm and the triggering pulse rise together.
REQ-020 ALARM SHALL be sticky; only clear or reset leaves it. Detection and counting SHALL continue in ALARM.
REQ-021 When clear is high at an edge, the block SHALL go to IDLE, zero net_wraps, drop both pulses and alarm, and ignore any coincident wrap (clear wins).
REQ-022 After clear deasserts, the first sample SHALL again only load q_prev (IDLE->TRACK, no detection).

Reset
REQ-023 While reset is low: state=IDLE, q_prev=0, net_wraps=0, ovf_pulse=0, unf_pulse=0, alarm=0, asynchronously.
REQ-024 Reset asserted mid-operation SHALL discard all history. The first edge after release SHALL behave as in REQ-018.

Structure
REQ-025 The FSM state encoding (IDLE/TRACK/ALARM) and the saturation limits (+127/-128) SHALL live in a shared package, count_mon_pkg.
REQ-026 Wrap detection (q_prev register plus compare logic producing the raw ovf/unf flags) SHALL be one sub-module, wrap_detect. The FSM, the saturating counter and the output registers SHALL stay in the top module.

Verification
REQ-027 Reset low, then release; drive q_in 13,14,15,0 with m_in=1 -> one ovf_pulse the cycle after 0 is sampled; net_wraps=1; alarm=0.
REQ-028 Drive q_in 2,1,0,15 with m_in=0 from net_wraps=1 -> one unf_pulse; net_wraps=0.
REQ-029 THRESH=4; drive four up-wraps -> alarm rises with the fourth ovf_pulse. Then drive one down-wrap -> net_wraps=3 and alarm stays 1.
REQ-030 Drive 15->0 with m_in=0, then 0->15 with m_in=1, then 5->9 -> no pulses and net_wraps unchanged.
REQ-031 Drive 130 up-wraps -> net_wraps holds 127. Assert clear on the same edge as a wrap -> net_wraps=0, no pulse, alarm=0, state IDLE.
REQ-032 Pull reset low mid-count with net_wraps=3; release with q_in=0 after q_in was 15 before reset -> no ovf_pulse on the first edge, and all outputs remain 0.
